// File: rtl/dmem_bus_if.sv
// Bus between the memory stage and the data-memory controller.
// The stage drives the request side; the controller answers with
// data_valid, load_data, err and stall.
interface dmem_bus_if;
  logic        request;
  logic        we_re;
  logic [3:0]  mask;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        data_valid;
  logic [31:0] load_data;
  logic        err;
  logic        stall;

  modport master (
    output request, we_re, mask, addr, store_data,
    input  data_valid, load_data, err, stall
  );

  modport slave (
    input  request, we_re, mask, addr, store_data,
    output data_valid, load_data, err, stall
  );
endinterface

// File: rtl/dmem_bus_ctrl.sv
// Fixed-latency data-memory controller with a byte-maskable word array.
// A request is accepted in IDLE, waits LATENCY cycles in WAIT, and the
// array access happens on the edge that enters RESP, where data_valid pulses.
module dmem_bus_ctrl #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst,
  dmem_bus_if.slave  bus
);

  localparam int         AW   = $clog2(DEPTH);
  localparam logic [3:0] LAT  = 4'(LATENCY);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;

  logic          we_q;
  logic [3:0]    mask_q;
  logic [AW-1:0] idx_q;
  logic          oob_q;
  logic [31:0]   wdata_q;
  logic [31:0]   load_data_q;

  logic [31:0]   mem [DEPTH];

  logic          reqOob;
  logic [AW-1:0] reqIdx;
  logic          accept;
  logic          commit;
  logic          cmdWe;
  logic [3:0]    cmdMask;
  logic [AW-1:0] cmdIdx;
  logic          cmdOob;
  logic [31:0]   cmdWdata;

  // Anything above the word-index bits being set means the address is off the end of the array.
  assign reqOob = (bus.addr >> (AW + 2)) != 32'd0;
  assign reqIdx = bus.addr[AW+1:2];
  assign accept = (state_q == IDLE) && bus.request;

  // With zero latency the commit edge is also the acceptance edge, so the live inputs are used there.
  always_comb begin
    if (state_q == IDLE) begin
      cmdWe    = bus.we_re;
      cmdMask  = bus.mask;
      cmdIdx   = reqIdx;
      cmdOob   = reqOob;
      cmdWdata = bus.store_data;
    end else begin
      cmdWe    = we_q;
      cmdMask  = mask_q;
      cmdIdx   = idx_q;
      cmdOob   = oob_q;
      cmdWdata = wdata_q;
    end
  end

  // Next-state logic: acceptance, latency countdown, abort on a dropped request, single-cycle response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.request) begin
          cnt_d   = LAT;
          state_d = (LAT == 4'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (!bus.request) begin
          cnt_d   = 4'd0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // The array is touched only on the edge that moves the FSM into RESP.
  assign commit = (state_d == RESP);

  // FSM, captured transaction fields and the load result register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      mask_q      <= 4'd0;
      idx_q       <= '0;
      oob_q       <= 1'b0;
      wdata_q     <= 32'd0;
      load_data_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= bus.we_re;
        mask_q  <= bus.mask;
        idx_q   <= reqIdx;
        oob_q   <= reqOob;
        wdata_q <= bus.store_data;
      end
      if (commit && !cmdWe) begin
        load_data_q <= cmdOob ? 32'd0 : mem[cmdIdx];
      end
    end
  end

  // Byte-masked store into the array; contents survive reset, and nothing is written while reset is held.
  always_ff @(posedge clk) begin
    if (rst && commit && cmdWe && !cmdOob) begin
      for (int i = 0; i < 4; i++) begin
        if (cmdMask[i]) mem[cmdIdx][8*i +: 8] <= cmdWdata[8*i +: 8];
      end
    end
  end

  assign bus.data_valid = (state_q == RESP);
  assign bus.err        = (state_q == RESP) && oob_q;
  assign bus.load_data  = load_data_q;
  assign bus.stall      = bus.request && !bus.data_valid;

endmodule
